mem_bus_arbiter: RTL and testbench

Two-master arbiter and handshake sequencer for the shared 32-bit memory bus (RAM, ROM, MMIO).
- Shares the bus between the debug unit (dbgu32 side) and the CPU (picorv32 native interface).
- Owns bus_op and generates the per-master ready pulse after a programmable number of wait cycles.
- Replaces the combinational debug/CPU mux and the free-running ready toggle at top level.

---
 rtl/mem_bus_arb_pkg.sv | 16 +
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Holds the FSM state encoding, the owner encoding and the wait counter width.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master (debug unit / CPU) arbiter and handshake sequencer for the shared memory bus.
// Optional round-robin grant between simultaneous requesters: define MEM_BUS_ARB_RR_EN.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_run,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_wstrb,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ready,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_op,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  output logic              owner_dbg
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_badWaitCycles
    $error("mem_bus_arbiter: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [WAIT_CNT_W-1:0] LastCnt = WAIT_CNT_W'(WAIT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  cpuReq;
  logic                  anyReq;
  logic                  winner;
  logic                  busActive;

  assign cpuReq = cpu_valid & cpu_run;
  assign anyReq = dbg_valid | cpuReq;

`ifdef MEM_BUS_ARB_RR_EN
  logic lastOwner_q, lastOwner_d;

  // On a tie the grant alternates away from whoever finished last.
  always_comb begin
    if (dbg_valid && cpuReq) begin
      winner = (lastOwner_q == OWN_DBG) ? OWN_CPU : OWN_DBG;
    end else begin
      winner = dbg_valid ? OWN_DBG : OWN_CPU;
    end
  end

  always_comb begin
    lastOwner_d = lastOwner_q;
    if (state_q == RESP) begin
      lastOwner_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastOwner_q <= OWN_CPU;
    end else begin
      lastOwner_q <= lastOwner_d;
    end
  end
`else
  always_comb begin
    winner = dbg_valid ? OWN_DBG : OWN_CPU;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Grants are only taken in IDLE, so an in-flight transaction is never preempted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d = winner;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busActive = (state_q == ACCESS) || (state_q == RESP);
    bus_op    = busActive;
    owner_dbg = owner_q;
    bus_adr   = (owner_q == OWN_DBG) ? dbg_adr : cpu_adr;
    bus_wdata = (owner_q == OWN_DBG) ? dbg_wdata : cpu_wdata;
    bus_wstrb = 4'h0;
    if (busActive) begin
      bus_wstrb = (owner_q == OWN_DBG) ? dbg_wstrb : cpu_wstrb;
    end
    dbg_ready = (state_q == RESP) && (owner_q == OWN_DBG);
    cpu_ready = (state_q == RESP) && (owner_q == OWN_CPU);
    dbg_rdata = dbg_ready ? bus_rdata : 32'h0;
    cpu_rdata = cpu_ready ? bus_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then random traffic,
// compared against a transaction-timeline model (grant time, completion time, owner).
module tb_mem_bus_arbiter;

  localparam int W  = 3;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          cpu_run;
  logic          dbg_valid;
  logic [AW-1:0] dbg_adr;
  logic [31:0]   dbg_wdata;
  logic [3:0]    dbg_wstrb;
  logic [31:0]   dbg_rdata;
  logic          dbg_ready;
  logic          cpu_valid;
  logic [AW-1:0] cpu_adr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          bus_op;
  logic [AW-1:0] bus_adr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_wstrb;
  logic [31:0]   bus_rdata;
  logic          owner_dbg;

  int checks = 0;
  int errors = 0;

  // Model: one outstanding transaction granted at gTime, finishing (ready) at dTime.
  int cyc    = 0;
  bit gValid = 0;
  int gTime  = 0;
  int dTime  = 0;
  bit mOwner = 0;
`ifdef MEM_BUS_ARB_RR_EN
  bit mPrev  = 0;
`endif

  mem_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_run   (cpu_run),
    .dbg_valid (dbg_valid),
    .dbg_adr   (dbg_adr),
    .dbg_wdata (dbg_wdata),
    .dbg_wstrb (dbg_wstrb),
    .dbg_rdata (dbg_rdata),
    .dbg_ready (dbg_ready),
    .cpu_valid (cpu_valid),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_op    (bus_op),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata),
    .owner_dbg (owner_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic checkOutput(input bit rstIn);
    bit active;
    bit isResp;
    bit dReq;
    bit cReq;
    bit win;
    active = gValid && (cyc > gTime) && (cyc <= dTime);
    isResp = active && (cyc == dTime);

    checkOne("bus_op", 32'(bus_op), 32'(active));
    checkOne("owner_dbg", 32'(owner_dbg), 32'(mOwner));
    checkOne("dbg_ready", 32'(dbg_ready), 32'(isResp && mOwner));
    checkOne("cpu_ready", 32'(cpu_ready), 32'(isResp && !mOwner));
    checkOne("bus_wstrb", 32'(bus_wstrb),
             active ? 32'(mOwner ? dbg_wstrb : cpu_wstrb) : 32'h0);
    if (active) begin
      checkOne("bus_adr", bus_adr, mOwner ? dbg_adr : cpu_adr);
      checkOne("bus_wdata", bus_wdata, mOwner ? dbg_wdata : cpu_wdata);
    end
    if (isResp && mOwner) checkOne("dbg_rdata", dbg_rdata, bus_rdata);
    else if (!mOwner)     checkOne("dbg_rdata_idle", dbg_rdata, 32'h0);
    if (isResp && !mOwner) checkOne("cpu_rdata", cpu_rdata, bus_rdata);
    else if (mOwner)       checkOne("cpu_rdata_idle", cpu_rdata, 32'h0);

    if (rstIn) begin
      gValid = 0;
      mOwner = 0;
`ifdef MEM_BUS_ARB_RR_EN
      mPrev  = 0;
`endif
    end else begin
`ifdef MEM_BUS_ARB_RR_EN
      if (isResp) mPrev = mOwner;
`endif
      if (!active) begin
        dReq = dbg_valid;
        cReq = cpu_valid && cpu_run;
        if (dReq || cReq) begin
`ifdef MEM_BUS_ARB_RR_EN
          win = (dReq && cReq) ? !mPrev : dReq;
`else
          win = dReq;
`endif
          gValid = 1;
          gTime  = cyc;
          dTime  = cyc + W + 1;
          mOwner = win;
        end
      end
    end
    cyc++;
  endtask

  // Drive one cycle's inputs just after the edge, check on the falling edge.
  task automatic applyStimulus(input bit rst, input bit run, input bit dv, input bit cv,
                               input logic [31:0] dAdr, input logic [31:0] cAdr,
                               input logic [3:0] dStrb, input logic [3:0] cStrb,
                               input logic [31:0] rdata);
    @(posedge clk);
    #1;
    reset     = rst;
    cpu_run   = run;
    dbg_valid = dv;
    cpu_valid = cv;
    dbg_adr   = dAdr;
    cpu_adr   = cAdr;
    dbg_wstrb = dStrb;
    cpu_wstrb = cStrb;
    dbg_wdata = $urandom;
    cpu_wdata = $urandom;
    bus_rdata = rdata;
    @(negedge clk);
    checkOutput(rst);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 1, 0, 0, $urandom, $urandom, 4'($urandom), 4'($urandom), $urandom);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cpu_run   = 1'b0;
    dbg_valid = 1'b0;
    cpu_valid = 1'b0;
    dbg_adr   = '0;
    cpu_adr   = '0;
    dbg_wdata = '0;
    cpu_wdata = '0;
    dbg_wstrb = '0;
    cpu_wstrb = '0;
    bus_rdata = '0;
    repeat (3) @(posedge clk);

    // Reset state, then a CPU read of 0x20000 returning DEADBEEF.
    idleCycles(2);
    for (int i = 0; i < W + 2; i++) begin
      applyStimulus(0, 1, 0, 1, $urandom, 32'h0002_0000, 4'h0, 4'h0, 32'hDEAD_BEEF);
    end
    idleCycles(2);

    // Simultaneous debug write and CPU request.
    for (int i = 0; i < 2 * (W + 2) + 1; i++) begin
      applyStimulus(0, 1, 1, 1, $urandom, $urandom, 4'hF, 4'h3, $urandom);
    end
    idleCycles(2);

    // Both held for four transactions.
    for (int i = 0; i < 4 * (W + 2); i++) begin
      applyStimulus(0, 1, 1, 1, $urandom, $urandom, 4'hF, 4'($urandom), $urandom);
    end
    idleCycles(2);

    // CPU masked by cpu_run for 20 cycles, then released.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1, $urandom, $urandom, 4'h0, 4'h0, $urandom);
    end
    for (int i = 0; i < W + 2; i++) begin
      applyStimulus(0, 1, 0, 1, $urandom, $urandom, 4'h0, 4'h0, $urandom);
    end
    idleCycles(2);

    // Reset during the second ACCESS cycle aborts without a ready.
    applyStimulus(0, 1, 0, 1, $urandom, $urandom, 4'h0, 4'h0, $urandom);
    applyStimulus(0, 1, 0, 1, $urandom, $urandom, 4'h0, 4'h0, $urandom);
    applyStimulus(1, 1, 0, 1, $urandom, $urandom, 4'h0, 4'h0, $urandom);
    idleCycles(W + 2);

    // Debug arrives while the CPU owns the bus; CPU completes first.
    for (int i = 0; i < 2 * (W + 2) + 1; i++) begin
      applyStimulus(0, 1, i >= 2, i <= W + 1, $urandom, $urandom,
                    4'($urandom), 4'($urandom), $urandom);
    end
    idleCycles(2);

    // Random traffic with occasional resets and protocol violations.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                    $urandom, $urandom, 4'($urandom), 4'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
